t05_histogram_rmw: RTL and testbench
====================================

Name: t05_histogram_rmw

Overview:
- Parametrised successor to the team's byte histogram.
- Accepts a symbol stream over a valid/ready handshake and counts occurrences per symbol in an external single-port SRAM, using a read-modify-write per symbol.
- Clears all bins at the start of each file, tolerates configurable SRAM read latency, and saturates counts.
- Sits between the SPI byte source and the histogram SRAM; reports the file total and completion to the top-level controller.

Parameters:
SYM_W, 8, symbol width; bin count NBINS = 2**SYM_W, bin address = symbol value
CNT_W, 32, width of each bin count and of mem_wdata/mem_rdata
TOT_W, 32, width of the total symbol counter
RD_LAT, 2, cycles from the mem_rd edge to mem_rdata valid (range 1..7)
EOF_SYM, 8'h1A, end-of-file symbol (SYM_W bits)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  controller enable; 0 freezes all state
start  in  1  single-cycle pulse: begin a new file
sym_valid  in  1  sym_data valid
sym_ready  out  1  block accepts a symbol this cycle
sym_data  in  SYM_W  input symbol
mem_addr  out  SYM_W  SRAM address
mem_rd  out  1  SRAM read strobe
mem_wr  out  1  SRAM write strobe
mem_wdata  out  CNT_W  SRAM write data
mem_rdata  in  CNT_W  SRAM read data
busy  out  1  high in any state other than IDLE and DONE
done  out  1  file complete; held until the next start
total  out  TOT_W  symbols counted in the file, EOF included
sat  out  1  sticky: a bin or the total hit its maximum

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0: sym_ready, mem_rd, mem_wr, mem_addr, mem_wdata, busy, done, total, sat. Internal counters are 0. SRAM contents are untouched. Reset mid-operation abandons any in-flight read-modify-write.
- en=0: all registers hold. mem_rd, mem_wr and sym_ready are forced to 0 combinationally. start is ignored.
- IDLE:
  - start -> CLEAR; total and sat are cleared; done is cleared.
  - sym_valid is ignored.
- CLEAR: one bin per cycle, mem_wr=1, mem_wdata=0, mem_addr = clr_cnt, for addresses 0..NBINS-1. After writing address NBINS-1 -> ACCEPT. This takes exactly NBINS cycles.
- ACCEPT:
  - sym_ready=1.
  - On sym_valid&sym_ready: latch sym_data into sym_q, total++ (saturating at all-ones, sets sat), -> READ.
- READ: mem_rd=1 for one cycle, mem_addr=sym_q -> WAITRD with lat_cnt=0.
- WAITRD: lat_cnt increments each cycle. When lat_cnt==RD_LAT-1, capture mem_rdata -> WRITE.
- WRITE: mem_wr=1, mem_addr=sym_q, mem_wdata = mem_rdata_q+1; if mem_rdata_q is all-ones, write all-ones and set sat.
  - sym_q==EOF_SYM -> DONE.
  - Otherwise -> ACCEPT.
- DONE:
  - done=1 and busy=0.
  - total holds its final value.
  - sym_ready=0.
  - start -> CLEAR (new file).
- Write-before-read ordering: the write completes before the next READ, so back-to-back identical symbols accumulate correctly with no forwarding.
- Timing:
  - Per-symbol occupancy is RD_LAT+3 cycles (ACCEPT, READ, RD_LAT waits, WRITE).
  - Sustained sym_ready duty is therefore 1 in RD_LAT+3.
- mem_rd and mem_wr are never high in the same cycle.
- mem_addr holds its last value when both strobes are low.
- start while busy (CLEAR..WRITE) is ignored.
- start coinciding with en=0 is ignored.
- EOF is counted in its own bin and in total.
- A stream with no EOF keeps the block in ACCEPT indefinitely.

Test Plan:
- Reset, then start; SRAM model preloaded with garbage, SYM_W=8 -> 256 consecutive zero writes to addresses 0..255; sym_ready first rises on cycle 257.
- Stream "A","B","A",0x1A with RD_LAT=2 -> bins 0x41=2, 0x42=1, 0x1A=1; total=4; done=1; each symbol occupies 5 cycles.
- Back-to-back 0x55 repeated 10 times then EOF, sym_valid held high -> bin 0x55=10, no lost increments.
- Bin 0x10 preset to 0xFFFFFFFF after CLEAR (backdoor), send 0x10 then EOF -> bin stays 0xFFFFFFFF; sat=1 until the next start.
- en dropped for 3 cycles during WAITRD, and start pulsed mid-stream -> strobes 0 while en=0; final counts are identical to the uninterrupted run; the mid-stream start has no effect.
- Async rst asserted mid-WRITE, then start and stream "Z",EOF -> outputs 0 immediately on rst; the new run has total=2 and bin 0x5A=1.

Source files
------------

// File: rtl/t05_histogram_rmw.sv
// t05_histogram_rmw: per-symbol read-modify-write histogram over an external single-port SRAM
//   clk, rst (async, active-high)      clock and reset
//   en                                 0 holds all state and masks strobes/ready
//   start                              begin a new file: clear all bins, then count
//   sym_valid/sym_ready/sym_data       symbol stream handshake
//   mem_addr/mem_rd/mem_wr             SRAM address and strobes
//   mem_wdata/mem_rdata                SRAM write and read data (read data RD_LAT cycles after mem_rd)
//   busy/done/total/sat                status: active, file complete, symbol count, sticky saturation
module t05_histogram_rmw #(
    parameter int SYM_W = 8,
    parameter int CNT_W = 32,
    parameter int TOT_W = 32,
    parameter int RD_LAT = 2,
    parameter logic [SYM_W-1:0] EOF_SYM = SYM_W'('h1A)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [SYM_W-1:0] sym_data,
    output logic [SYM_W-1:0] mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [CNT_W-1:0] mem_wdata,
    input  logic [CNT_W-1:0] mem_rdata,
    output logic             busy,
    output logic             done,
    output logic [TOT_W-1:0] total,
    output logic             sat
);
    typedef enum logic [2:0] {IDLE, CLEAR, ACCEPT, READ, WAITRD, WRITE, DONE} state_t;
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);
    state_t state, state_d;
    logic [SYM_W-1:0] clr_cnt, sym_q, addr_q;
    logic [2:0] lat_cnt;
    logic [CNT_W-1:0] rdata_q, wdata_q, wr_val;
    logic take, restart, lat_hit;
    assign take = state == ACCEPT && sym_valid;
    assign restart = start && (state == IDLE || state == DONE);
    assign lat_hit = state == WAITRD && lat_cnt == LAT_LAST;
    assign wr_val = &rdata_q ? rdata_q : rdata_q + CNT_W'(1);
    assign sym_ready = en && state == ACCEPT;
    assign mem_rd = en && state == READ;
    assign mem_wr = en && (state == CLEAR || state == WRITE);
    // address and data are only meaningful under a strobe; otherwise the last driven value is held
    assign mem_addr = (mem_rd || mem_wr) ? (state == CLEAR ? clr_cnt : sym_q) : addr_q;
    assign mem_wdata = mem_wr ? (state == CLEAR ? '0 : wr_val) : wdata_q;
    assign busy = state != IDLE && state != DONE;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? CLEAR : IDLE;
            CLEAR:   state_d = &clr_cnt ? ACCEPT : CLEAR;
            ACCEPT:  state_d = sym_valid ? READ : ACCEPT;
            READ:    state_d = WAITRD;
            WAITRD:  state_d = lat_hit ? WRITE : WAITRD;
            WRITE:   state_d = sym_q == EOF_SYM ? DONE : ACCEPT;
            DONE:    state_d = start ? CLEAR : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
            lat_cnt <= '0;
            sym_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            total   <= '0;
            sat     <= 1'b0;
            done    <= 1'b0;
        end else if (en) begin
            state   <= state_d;
            clr_cnt <= state == CLEAR ? clr_cnt + SYM_W'(1) : '0;
            lat_cnt <= state == WAITRD ? lat_cnt + 3'd1 : '0;
            if (mem_rd || mem_wr) addr_q <= mem_addr;
            if (mem_wr) wdata_q <= mem_wdata;
            if (take) sym_q <= sym_data;
            if (lat_hit) rdata_q <= mem_rdata;
            total   <= restart ? '0 : (take && !(&total)) ? total + TOT_W'(1) : total;
            // total reaching all-ones or a bin already at all-ones marks saturation
            sat     <= restart ? 1'b0 : sat || (take && &total[TOT_W-1:1]) || (state == WRITE && &rdata_q);
            done    <= restart ? 1'b0 : done || (state == WRITE && sym_q == EOF_SYM);
        end
    end
endmodule

// File: tb/tb_t05_histogram_rmw.sv
// tb_t05_histogram_rmw: directed scoreboard bench for t05_histogram_rmw with an SRAM model
module tb_t05_histogram_rmw;
    localparam int LAT = 2;
    logic clk, rst, en, start, sym_valid, sym_ready, mem_rd, mem_wr, busy, done, sat;
    logic [7:0] sym_data, mem_addr;
    logic [31:0] mem_wdata, mem_rdata, total;
    logic fill, preset_en, mon_en;
    logic [31:0] mem [256];
    logic [31:0] pipe [LAT];
    logic [31:0] exp_cnt [256];
    logic [39:0] obs_buf [1024];
    logic [39:0] exp_q [$];
    int obs_n, rd_n, overlap, cyc, hs_cyc, hs_prev;
    int checks, errors;

    t05_histogram_rmw #(.RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .total(total), .sat(sat)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    assign mem_rdata = pipe[LAT-1];
    always @(posedge clk) begin
        if (fill) for (int i = 0; i < 256; i++) mem[i] <= 32'hDEAD0000 | 32'(i);
        if (preset_en) mem[8'h10] <= '1;
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) pipe[0] <= mem[mem_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    initial begin
        obs_n = 0;
        overlap = 0;
        cyc = 0;
    end
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mon_en && mem_wr && obs_n < 1024) begin
            obs_buf[obs_n] = {mem_addr, mem_wdata};
            obs_n = obs_n + 1;
        end
        if (mem_rd && mem_wr) overlap = overlap + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_file();
        int n = 0;
        int good = 0;
        mon_en = 0;
        start = 1;
        step();
        start = 0;
        chk("start_clears", {30'd0, sat, done, total}, 0);
        while (!sym_ready && n < 300) begin
            if (mem_wr && mem_addr == 8'(n) && mem_wdata == 0) good++;
            step();
            n++;
        end
        chk("clear_cycles", n, 256);
        chk("clear_writes", good, 256);
        for (int i = 0; i < 256; i++) exp_cnt[i] = 0;
        exp_q.delete();
        rd_n = obs_n;
        mon_en = 1;
    endtask

    task automatic send(input logic [7:0] s, input bit stall);
        int n = 0;
        int bad = 0;
        logic [39:0] e;
        sym_valid = 1;
        sym_data = s;
        while (!sym_ready && n < 50) begin
            step();
            n++;
        end
        chk("ready_wait", sym_ready, 1);
        exp_cnt[s] = &exp_cnt[s] ? exp_cnt[s] : exp_cnt[s] + 1;
        exp_q.push_back({s, exp_cnt[s]});
        hs_prev = hs_cyc;
        hs_cyc = cyc;
        step();
        if (stall) begin
            step();
            en = 0;
            start = 1;
            repeat (3) begin
                step();
                bad += int'(mem_rd | mem_wr | sym_ready);
            end
            en = 1;
            start = 0;
            chk("en_low_strobes", bad, 0);
        end
        n = 0;
        while (obs_n <= rd_n && n < 30) begin
            step();
            n++;
        end
        e = exp_q.pop_front();
        if (obs_n <= rd_n) chk("write_wait", 0, 1);
        else begin
            chk("bin_write", obs_buf[rd_n], e);
            rd_n++;
        end
    endtask

    task automatic end_file(input int tot);
        chk("done", done, 1);
        chk("busy_in_done", busy, 0);
        chk("ready_in_done", sym_ready, 0);
        chk("total", total, tot);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rd_n = 0;
        hs_cyc = 0;
        hs_prev = 0;
        rst = 1; en = 1; start = 0; sym_valid = 0; sym_data = 0;
        fill = 1; preset_en = 0; mon_en = 0;
        step();
        fill = 0;
        step();
        chk("rst_ctrl", {sym_ready, mem_rd, mem_wr, busy, done, sat, mem_addr}, 0);
        chk("rst_data", {mem_wdata, total}, 0);
        rst = 0;
        sym_valid = 1;
        step();
        step();
        chk("idle_ignores_valid", {busy, total}, 0);
        sym_valid = 0;

        start_file();
        chk("clear_bin00", mem[0], 0);
        chk("clear_binff", mem[255], 0);
        chk("accept_busy", busy, 1);

        send(8'h41, 0);
        send(8'h42, 0);
        chk("occupancy", hs_cyc - hs_prev, LAT + 3);
        send(8'h41, 0);
        send(8'h1A, 0);
        sym_valid = 0;
        end_file(4);
        chk("bin41", mem[8'h41], 2);
        chk("bin42", mem[8'h42], 1);
        chk("bin1a", mem[8'h1A], 1);

        start_file();
        repeat (10) send(8'h55, 0);
        chk("b2b_occupancy", hs_cyc - hs_prev, LAT + 3);
        send(8'h1A, 0);
        sym_valid = 0;
        end_file(11);
        chk("bin55", mem[8'h55], 10);
        chk("sat_clear_run", sat, 0);

        start_file();
        preset_en = 1;
        step();
        preset_en = 0;
        exp_cnt[8'h10] = '1;
        send(8'h10, 0);
        send(8'h1A, 0);
        sym_valid = 0;
        end_file(2);
        chk("bin10_sat", mem[8'h10], 32'hFFFFFFFF);
        chk("sat_set", sat, 1);
        step();
        chk("sat_held", sat, 1);

        start_file();
        send(8'h41, 1);
        start = 1;
        send(8'h42, 0);
        start = 0;
        send(8'h41, 0);
        send(8'h1A, 0);
        sym_valid = 0;
        end_file(4);
        chk("stall_bin41", mem[8'h41], 2);
        chk("stall_bin42", mem[8'h42], 1);
        chk("stall_bin1a", mem[8'h1A], 1);

        start_file();
        sym_valid = 1;
        sym_data = 8'h51;
        for (int n = 0; n < 20 && !sym_ready; n++) step();
        step();
        sym_valid = 0;
        for (int n = 0; n < 20 && !mem_wr; n++) step();
        chk("reach_write", mem_wr, 1);
        rst = 1;
        #1;
        chk("rst_async_ctrl", {sym_ready, mem_rd, mem_wr, busy, done, sat, mem_addr}, 0);
        chk("rst_async_data", {mem_wdata, total}, 0);
        step();
        rst = 0;
        step();
        start_file();
        send(8'h5A, 0);
        send(8'h1A, 0);
        sym_valid = 0;
        end_file(2);
        chk("bin5a", mem[8'h5A], 1);
        chk("bin51_abandoned", mem[8'h51], 0);
        chk("rd_wr_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
